// File: rtl/vx_mem_tag_remap_if.sv
// Memory request/response bus shared by the cache side and the fabric side of the tag remapper.
// The master drives requests and accepts responses; the slave is the opposite end.
interface vx_mem_tag_remap_if #(
  parameter int unsigned ADDR_WIDTH = 26,
  parameter int unsigned DATA_SIZE  = 64,
  parameter int unsigned TAG_WIDTH  = 12
) ();
  logic                     req_valid;
  logic                     req_rw;
  logic [ADDR_WIDTH-1:0]    req_addr;
  logic [DATA_SIZE*8-1:0]   req_data;
  logic [DATA_SIZE-1:0]     req_byteen;
  logic [TAG_WIDTH-1:0]     req_tag;
  logic                     req_ready;

  logic                     rsp_valid;
  logic [DATA_SIZE*8-1:0]   rsp_data;
  logic [TAG_WIDTH-1:0]     rsp_tag;
  logic                     rsp_ready;

  modport master (
    output req_valid, req_rw, req_addr, req_data, req_byteen, req_tag, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_tag
  );

  modport slave (
    input  req_valid, req_rw, req_addr, req_data, req_byteen, req_tag, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_tag
  );
endinterface

// File: rtl/vx_mem_tag_remap.sv
// Memory tag remapper: replaces wide cache read tags with compact IDs from a free pool,
// remembers the original tag per ID and restores it on the matching response.
// Writes carry no ID and expect no response.
module vx_mem_tag_remap #(
  parameter int unsigned NUM_IDS      = 16,
  parameter int unsigned ADDR_WIDTH   = 26,
  parameter int unsigned DATA_SIZE    = 64,
  parameter int unsigned TAG_IN_WIDTH = 12,
  localparam int unsigned ID_WIDTH    = $clog2(NUM_IDS),
  localparam int unsigned CNT_WIDTH   = $clog2(NUM_IDS + 1)
) (
  input  logic                 clk,
  input  logic                 reset,
  vx_mem_tag_remap_if.slave    in_bus,
  vx_mem_tag_remap_if.master   out_bus,
  output logic [CNT_WIDTH-1:0] outstanding
);

  localparam int unsigned DATA_WIDTH = DATA_SIZE * 8;

  // ID pool state
  logic [NUM_IDS-1:0]      free_mask_q, free_mask_d;
  logic [CNT_WIDTH-1:0]    count_q, count_d;
  logic [TAG_IN_WIDTH-1:0] tag_table [NUM_IDS];

  // Request output register
  logic                    oreq_valid_q;
  logic                    oreq_rw_q;
  logic [ADDR_WIDTH-1:0]   oreq_addr_q;
  logic [DATA_WIDTH-1:0]   oreq_data_q;
  logic [DATA_SIZE-1:0]    oreq_byteen_q;
  logic [ID_WIDTH-1:0]     oreq_tag_q;

  // Response output register
  logic                    irsp_valid_q;
  logic [DATA_WIDTH-1:0]   irsp_data_q;
  logic [TAG_IN_WIDTH-1:0] irsp_tag_q;

  logic                    any_free;
  logic                    stage_free;
  logic                    rsp_stage_free;
  logic                    req_fire;
  logic                    alloc;
  logic                    rsp_fire;
  logic                    free_en;
  logic [ID_WIDTH-1:0]     alloc_id;
  logic [NUM_IDS-1:0]      alloc_mask;
  logic [NUM_IDS-1:0]      release_mask;

  assign any_free       = |free_mask_q;
  assign stage_free     = ~oreq_valid_q | out_bus.req_ready;
  assign rsp_stage_free = ~irsp_valid_q | in_bus.rsp_ready;

  // A read needs a free ID; a write only needs the output stage.
  assign in_bus.req_ready  = stage_free & (in_bus.req_rw | any_free);
  assign req_fire          = in_bus.req_valid & in_bus.req_ready;
  assign alloc             = req_fire & ~in_bus.req_rw;
  assign rsp_fire          = out_bus.rsp_valid & rsp_stage_free;
  // A response for an unallocated ID is forwarded but must not touch the pool.
  assign free_en           = rsp_fire & ~free_mask_q[out_bus.rsp_tag];

  assign out_bus.req_valid  = oreq_valid_q;
  assign out_bus.req_rw     = oreq_rw_q;
  assign out_bus.req_addr   = oreq_addr_q;
  assign out_bus.req_data   = oreq_data_q;
  assign out_bus.req_byteen = oreq_byteen_q;
  assign out_bus.req_tag    = oreq_tag_q;
  assign out_bus.rsp_ready  = rsp_stage_free;

  assign in_bus.rsp_valid   = irsp_valid_q;
  assign in_bus.rsp_data    = irsp_data_q;
  assign in_bus.rsp_tag     = irsp_tag_q;

  assign outstanding        = count_q;

  // Priority pick of the lowest-index free ID (scan high to low so the lowest wins).
  always_comb begin
    alloc_id = '0;
    for (int i = NUM_IDS - 1; i >= 0; i--) begin
      if (free_mask_q[i]) alloc_id = ID_WIDTH'(i);
    end
  end

  // Next pool mask and occupancy; alloc and free never target the same ID.
  always_comb begin
    alloc_mask   = {{(NUM_IDS-1){1'b0}}, alloc} << alloc_id;
    release_mask = {{(NUM_IDS-1){1'b0}}, free_en} << out_bus.rsp_tag;
    free_mask_d  = (free_mask_q & ~alloc_mask) | release_mask;
    count_d      = count_q;
    if (alloc && !free_en) begin
      count_d = count_q + CNT_WIDTH'(1);
    end else if (!alloc && free_en) begin
      count_d = count_q - CNT_WIDTH'(1);
    end
  end

  // ID pool and outstanding counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      free_mask_q <= '1;
      count_q     <= '0;
    end else begin
      free_mask_q <= free_mask_d;
      count_q     <= count_d;
    end
  end

  // Original cache tag per allocated ID; contents are don't-care while the ID is free.
  always_ff @(posedge clk) begin
    if (alloc) tag_table[alloc_id] <= in_bus.req_tag;
  end

  // Request stage: load on accept, hold while the fabric stalls, empty otherwise.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      oreq_valid_q  <= 1'b0;
      oreq_rw_q     <= 1'b0;
      oreq_addr_q   <= '0;
      oreq_data_q   <= '0;
      oreq_byteen_q <= '0;
      oreq_tag_q    <= '0;
    end else if (stage_free) begin
      oreq_valid_q <= req_fire;
      if (req_fire) begin
        oreq_rw_q     <= in_bus.req_rw;
        oreq_addr_q   <= in_bus.req_addr;
        oreq_data_q   <= in_bus.req_data;
        oreq_byteen_q <= in_bus.req_byteen;
        oreq_tag_q    <= in_bus.req_rw ? '0 : alloc_id;
      end
    end
  end

  // Response stage: capture data with the restored tag when the cache side can take it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      irsp_valid_q <= 1'b0;
      irsp_data_q  <= '0;
      irsp_tag_q   <= '0;
    end else if (rsp_stage_free) begin
      irsp_valid_q <= out_bus.rsp_valid;
      if (out_bus.rsp_valid) begin
        irsp_data_q <= out_bus.rsp_data;
        irsp_tag_q  <= tag_table[out_bus.rsp_tag];
      end
    end
  end

  // Responses must only name IDs that are currently allocated.
  unalloc_rsp_check : assert property (
    @(posedge clk) disable iff (reset) rsp_fire |-> !free_mask_q[out_bus.rsp_tag]
  );

endmodule

// File: tb/tb_vx_mem_tag_remap.sv
// Bench for the memory tag remapper with a 4-entry ID pool: directed scenarios followed by
// randomized traffic scored against a transaction-level model of the pool and both stages.
`timescale 1ns/1ps
module tb_vx_mem_tag_remap;
  localparam int unsigned NUM_IDS = 4;
  localparam int unsigned AW = 26;
  localparam int unsigned DS = 64;
  localparam int unsigned TW = 12;
  localparam int unsigned IW = 2;
  localparam int unsigned CW = 3;
  localparam int unsigned DW = DS * 8;

  typedef struct packed {
    logic          rw;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic [DS-1:0] byteen;
    logic [IW-1:0] tag;
  } oreq_t;

  typedef struct packed {
    logic [TW-1:0] tag;
    logic [DW-1:0] data;
  } irsp_t;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [CW-1:0] outstanding;
  int            n_checks = 0;
  int            n_fail = 0;
  logic [TW-1:0] id_tag [NUM_IDS];

  vx_mem_tag_remap_if #(.ADDR_WIDTH(AW), .DATA_SIZE(DS), .TAG_WIDTH(TW)) in_bus ();
  vx_mem_tag_remap_if #(.ADDR_WIDTH(AW), .DATA_SIZE(DS), .TAG_WIDTH(IW)) out_bus ();

  vx_mem_tag_remap #(
    .NUM_IDS(NUM_IDS), .ADDR_WIDTH(AW), .DATA_SIZE(DS), .TAG_IN_WIDTH(TW)
  ) dut (
    .clk(clk), .reset(reset), .in_bus(in_bus), .out_bus(out_bus), .outstanding(outstanding)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] rand_data();
    logic [DW-1:0] r;
    for (int i = 0; i < int'(DW / 32); i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    in_bus.req_valid  = 1'b0;
    in_bus.req_rw     = 1'b0;
    in_bus.req_addr   = '0;
    in_bus.req_data   = '0;
    in_bus.req_byteen = '0;
    in_bus.req_tag    = '0;
    in_bus.rsp_ready  = 1'b1;
    out_bus.req_ready = 1'b1;
    out_bus.rsp_valid = 1'b0;
    out_bus.rsp_data  = '0;
    out_bus.rsp_tag   = '0;
  endtask

  task automatic drive_read(input logic [TW-1:0] tag);
    in_bus.req_valid  = 1'b1;
    in_bus.req_rw     = 1'b0;
    in_bus.req_addr   = AW'($urandom);
    in_bus.req_data   = rand_data();
    in_bus.req_byteen = {$urandom, $urandom};
    in_bus.req_tag    = tag;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (out_bus.req_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset_out_req_valid: got %b want 0", out_bus.req_valid);
    end
    n_checks++;
    if (in_bus.rsp_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset_in_rsp_valid: got %b want 0", in_bus.rsp_valid);
    end
    n_checks++;
    if (in_bus.req_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_in_req_ready: got %b want 1", in_bus.req_ready);
    end
    n_checks++;
    if (out_bus.rsp_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_out_rsp_ready: got %b want 1", out_bus.rsp_ready);
    end
    n_checks++;
    if (outstanding !== 3'd0) begin
      n_fail++; $display("FAIL reset_outstanding: got %0d want 0", outstanding);
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_single_read();
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    drive_read(12'h5A3);
    a = in_bus.req_addr;
    d = rand_data();
    #1;
    n_checks++;
    if (in_bus.req_ready !== 1'b1) begin
      n_fail++; $display("FAIL single_in_req_ready: got %b want 1", in_bus.req_ready);
    end
    tick();
    in_bus.req_valid = 1'b0;
    n_checks++;
    if (out_bus.req_valid !== 1'b1 || out_bus.req_tag !== 2'd0 || out_bus.req_addr !== a) begin
      n_fail++;
      $display("FAIL single_out_req: got v=%b tag=%0d addr=%0h want v=1 tag=0 addr=%0h",
               out_bus.req_valid, out_bus.req_tag, out_bus.req_addr, a);
    end
    n_checks++;
    if (outstanding !== 3'd1) begin
      n_fail++; $display("FAIL single_outstanding_1: got %0d want 1", outstanding);
    end
    tick();
    out_bus.rsp_valid = 1'b1;
    out_bus.rsp_tag   = 2'd0;
    out_bus.rsp_data  = d;
    tick();
    out_bus.rsp_valid = 1'b0;
    n_checks++;
    if (in_bus.rsp_valid !== 1'b1 || in_bus.rsp_tag !== 12'h5A3 || in_bus.rsp_data !== d) begin
      n_fail++;
      $display("FAIL single_in_rsp: got v=%b tag=%0h want v=1 tag=5a3", in_bus.rsp_valid,
               in_bus.rsp_tag);
    end
    n_checks++;
    if (outstanding !== 3'd0) begin
      n_fail++; $display("FAIL single_outstanding_0: got %0d want 0", outstanding);
    end
    tick();
    n_checks++;
    if (in_bus.rsp_valid !== 1'b0) begin
      n_fail++; $display("FAIL single_rsp_once: got v=%b want 0", in_bus.rsp_valid);
    end
  endtask

  task automatic test_pool_full();
    logic [TW-1:0] tags [5];
    for (int k = 0; k < 5; k++) tags[k] = TW'($urandom);
    for (int k = 0; k < 4; k++) begin
      drive_read(tags[k]);
      #1;
      n_checks++;
      if (in_bus.req_ready !== 1'b1) begin
        n_fail++; $display("FAIL full_ready_%0d: got %b want 1", k, in_bus.req_ready);
      end
      tick();
      n_checks++;
      if (out_bus.req_valid !== 1'b1 || out_bus.req_tag !== IW'(k)) begin
        n_fail++;
        $display("FAIL full_id_%0d: got v=%b id=%0d want v=1 id=%0d", k, out_bus.req_valid,
                 out_bus.req_tag, k);
      end
      id_tag[k] = tags[k];
    end
    drive_read(tags[4]);
    #1;
    n_checks++;
    if (in_bus.req_ready !== 1'b0) begin
      n_fail++; $display("FAIL full_fifth_stalled: got %b want 0", in_bus.req_ready);
    end
    n_checks++;
    if (outstanding !== 3'd4) begin
      n_fail++; $display("FAIL full_outstanding_4: got %0d want 4", outstanding);
    end
    tick();
    n_checks++;
    if (out_bus.req_valid !== 1'b0) begin
      n_fail++; $display("FAIL full_no_issue: got v=%b want 0", out_bus.req_valid);
    end
    out_bus.rsp_valid = 1'b1;
    out_bus.rsp_tag   = 2'd2;
    out_bus.rsp_data  = rand_data();
    tick();
    out_bus.rsp_valid = 1'b0;
    n_checks++;
    if (in_bus.rsp_valid !== 1'b1 || in_bus.rsp_tag !== tags[2]) begin
      n_fail++;
      $display("FAIL full_rsp_id2: got v=%b tag=%0h want v=1 tag=%0h", in_bus.rsp_valid,
               in_bus.rsp_tag, tags[2]);
    end
    #1;
    n_checks++;
    if (in_bus.req_ready !== 1'b1) begin
      n_fail++; $display("FAIL full_fifth_ready: got %b want 1", in_bus.req_ready);
    end
    tick();
    in_bus.req_valid = 1'b0;
    n_checks++;
    if (out_bus.req_valid !== 1'b1 || out_bus.req_tag !== 2'd2 || outstanding !== 3'd4) begin
      n_fail++;
      $display("FAIL full_fifth_id: got v=%b id=%0d out=%0d want v=1 id=2 out=4",
               out_bus.req_valid, out_bus.req_tag, outstanding);
    end
    id_tag[2] = tags[4];
    tick();
  endtask

  task automatic test_write_order();
    logic [TW-1:0] tr;
    logic [AW-1:0] wa;
    logic [DW-1:0] wd;
    logic [DS-1:0] wb;
    tr = TW'($urandom);
    drive_read(tr);
    for (int k = 0; k < 3; k++) begin
      #1;
      n_checks++;
      if (in_bus.req_ready !== 1'b0) begin
        n_fail++; $display("FAIL order_read_stall_%0d: got %b want 0", k, in_bus.req_ready);
      end
      tick();
      n_checks++;
      if (out_bus.req_valid !== 1'b0) begin
        n_fail++; $display("FAIL order_nothing_passes_%0d: got %b want 0", k, out_bus.req_valid);
      end
    end
    out_bus.rsp_valid = 1'b1;
    out_bus.rsp_tag   = 2'd1;
    tick();
    out_bus.rsp_valid = 1'b0;
    n_checks++;
    if (in_bus.rsp_tag !== id_tag[1]) begin
      n_fail++; $display("FAIL order_rsp_id1: got %0h want %0h", in_bus.rsp_tag, id_tag[1]);
    end
    tick();
    n_checks++;
    if (out_bus.req_valid !== 1'b1 || out_bus.req_rw !== 1'b0 || out_bus.req_tag !== 2'd1) begin
      n_fail++;
      $display("FAIL order_read_first: got v=%b rw=%b id=%0d want v=1 rw=0 id=1",
               out_bus.req_valid, out_bus.req_rw, out_bus.req_tag);
    end
    id_tag[1] = tr;
    // Pool is full again: a write must still pass, with tag 0 and no allocation.
    wa = AW'($urandom); wd = rand_data(); wb = {$urandom, $urandom};
    in_bus.req_rw = 1'b1; in_bus.req_addr = wa; in_bus.req_data = wd; in_bus.req_byteen = wb;
    in_bus.req_tag = TW'($urandom);
    #1;
    n_checks++;
    if (in_bus.req_ready !== 1'b1) begin
      n_fail++; $display("FAIL order_write_ready_full: got %b want 1", in_bus.req_ready);
    end
    tick();
    in_bus.req_valid = 1'b0;
    n_checks++;
    if (out_bus.req_valid !== 1'b1 || out_bus.req_rw !== 1'b1 || out_bus.req_tag !== 2'd0 ||
        out_bus.req_addr !== wa || out_bus.req_data !== wd || out_bus.req_byteen !== wb ||
        outstanding !== 3'd4) begin
      n_fail++;
      $display("FAIL order_write_full: got v=%b rw=%b tag=%0d addr=%0h out=%0d want 1 1 0 %0h 4",
               out_bus.req_valid, out_bus.req_rw, out_bus.req_tag, out_bus.req_addr,
               outstanding, wa);
    end
    tick();
    for (int id = 0; id < 4; id++) begin
      out_bus.rsp_valid = 1'b1;
      out_bus.rsp_tag   = IW'(id);
      out_bus.rsp_data  = rand_data();
      wd = out_bus.rsp_data;
      tick();
      n_checks++;
      if (in_bus.rsp_valid !== 1'b1 || in_bus.rsp_tag !== id_tag[id] || in_bus.rsp_data !== wd)
      begin
        n_fail++;
        $display("FAIL order_drain_%0d: got v=%b tag=%0h want v=1 tag=%0h", id,
                 in_bus.rsp_valid, in_bus.rsp_tag, id_tag[id]);
      end
    end
    out_bus.rsp_valid = 1'b0;
    tick();
    n_checks++;
    if (outstanding !== 3'd0 || in_bus.rsp_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL order_drained: got out=%0d v=%b want 0 0", outstanding, in_bus.rsp_valid);
    end
    in_bus.req_valid = 1'b1; in_bus.req_rw = 1'b1; in_bus.req_addr = wa;
    tick();
    in_bus.req_valid = 1'b0;
    n_checks++;
    if (out_bus.req_valid !== 1'b1 || out_bus.req_rw !== 1'b1 || out_bus.req_tag !== 2'd0 ||
        outstanding !== 3'd0) begin
      n_fail++;
      $display("FAIL order_write_empty: got v=%b rw=%b tag=%0d out=%0d want 1 1 0 0",
               out_bus.req_valid, out_bus.req_rw, out_bus.req_tag, outstanding);
    end
    tick();
  endtask

  task automatic test_backpressure();
    logic [TW-1:0] tx, ty;
    logic [AW-1:0] ax, ay;
    tx = TW'($urandom); ty = TW'($urandom);
    out_bus.req_ready = 1'b0;
    drive_read(tx);
    ax = in_bus.req_addr;
    tick();
    drive_read(ty);
    ay = in_bus.req_addr;
    for (int k = 0; k < 3; k++) begin
      #1;
      n_checks++;
      if (in_bus.req_ready !== 1'b0) begin
        n_fail++; $display("FAIL bp_in_ready_%0d: got %b want 0", k, in_bus.req_ready);
      end
      tick();
      n_checks++;
      if (out_bus.req_valid !== 1'b1 || out_bus.req_tag !== 2'd0 || out_bus.req_addr !== ax) begin
        n_fail++;
        $display("FAIL bp_stable_%0d: got v=%b id=%0d addr=%0h want v=1 id=0 addr=%0h", k,
                 out_bus.req_valid, out_bus.req_tag, out_bus.req_addr, ax);
      end
    end
    out_bus.req_ready = 1'b1;
    #1;
    n_checks++;
    if (in_bus.req_ready !== 1'b1) begin
      n_fail++; $display("FAIL bp_release_ready: got %b want 1", in_bus.req_ready);
    end
    tick();
    in_bus.req_valid = 1'b0;
    n_checks++;
    if (out_bus.req_valid !== 1'b1 || out_bus.req_tag !== 2'd1 || out_bus.req_addr !== ay ||
        outstanding !== 3'd2) begin
      n_fail++;
      $display("FAIL bp_second: got v=%b id=%0d addr=%0h out=%0d want 1 1 %0h 2",
               out_bus.req_valid, out_bus.req_tag, out_bus.req_addr, outstanding, ay);
    end
    tick();
    out_bus.rsp_valid = 1'b1; out_bus.rsp_tag = 2'd1;
    tick();
    out_bus.rsp_tag = 2'd0;
    n_checks++;
    if (in_bus.rsp_tag !== ty) begin
      n_fail++; $display("FAIL bp_rsp_y: got %0h want %0h", in_bus.rsp_tag, ty);
    end
    tick();
    out_bus.rsp_valid = 1'b0;
    n_checks++;
    if (in_bus.rsp_tag !== tx || outstanding !== 3'd0) begin
      n_fail++;
      $display("FAIL bp_rsp_x: got tag=%0h out=%0d want %0h 0", in_bus.rsp_tag, outstanding, tx);
    end
    tick();
  endtask

  task automatic test_out_of_order();
    logic [TW-1:0] t [4];
    int order [4] = '{3, 0, 1, 2};
    for (int k = 0; k < 4; k++) begin
      t[k] = TW'($urandom);
      drive_read(t[k]);
      tick();
    end
    in_bus.req_valid = 1'b0;
    tick();
    n_checks++;
    if (outstanding !== 3'd4) begin
      n_fail++; $display("FAIL ooo_outstanding_4: got %0d want 4", outstanding);
    end
    for (int k = 0; k < 4; k++) begin
      out_bus.rsp_valid = 1'b1;
      out_bus.rsp_tag   = IW'(order[k]);
      if (k == 1) begin
        // Cache side stalls for one cycle: previous response must hold, new one must wait.
        in_bus.rsp_ready = 1'b0;
        #1;
        n_checks++;
        if (out_bus.rsp_ready !== 1'b0) begin
          n_fail++; $display("FAIL ooo_stall_ready: got %b want 0", out_bus.rsp_ready);
        end
        tick();
        n_checks++;
        if (in_bus.rsp_valid !== 1'b1 || in_bus.rsp_tag !== t[3] || outstanding !== 3'd3) begin
          n_fail++;
          $display("FAIL ooo_stall_hold: got v=%b tag=%0h out=%0d want 1 %0h 3",
                   in_bus.rsp_valid, in_bus.rsp_tag, outstanding, t[3]);
        end
        in_bus.rsp_ready = 1'b1;
      end
      tick();
      n_checks++;
      if (in_bus.rsp_valid !== 1'b1 || in_bus.rsp_tag !== t[order[k]] ||
          outstanding !== CW'(3 - k)) begin
        n_fail++;
        $display("FAIL ooo_rsp_id%0d: got v=%b tag=%0h out=%0d want 1 %0h %0d", order[k],
                 in_bus.rsp_valid, in_bus.rsp_tag, outstanding, t[order[k]], 3 - k);
      end
    end
    out_bus.rsp_valid = 1'b0;
    tick();
    n_checks++;
    if (in_bus.rsp_valid !== 1'b0) begin
      n_fail++; $display("FAIL ooo_no_duplicate: got v=%b want 0", in_bus.rsp_valid);
    end
  endtask

  task automatic test_alloc_free_reset();
    logic [TW-1:0] t0, t1;
    t0 = TW'($urandom); t1 = TW'($urandom);
    drive_read(t0);
    tick();
    drive_read(t1);
    tick();
    in_bus.req_valid = 1'b0;
    tick();
    n_checks++;
    if (outstanding !== 3'd2) begin
      n_fail++; $display("FAIL same_pre_outstanding: got %0d want 2", outstanding);
    end
    drive_read(TW'($urandom));
    out_bus.rsp_valid = 1'b1; out_bus.rsp_tag = 2'd0;
    tick();
    out_bus.rsp_valid = 1'b0;
    n_checks++;
    if (outstanding !== 3'd2 || out_bus.req_tag !== 2'd2 || in_bus.rsp_tag !== t0) begin
      n_fail++;
      $display("FAIL same_cycle: got out=%0d id=%0d tag=%0h want 2 2 %0h", outstanding,
               out_bus.req_tag, in_bus.rsp_tag, t0);
    end
    // Reset lands between clock edges with traffic in both stages.
    drive_read(TW'($urandom));
    reset = 1'b1;
    #1;
    n_checks++;
    if (out_bus.req_valid !== 1'b0 || in_bus.rsp_valid !== 1'b0 || outstanding !== 3'd0 ||
        in_bus.req_ready !== 1'b1 || out_bus.rsp_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL midreset: got oreq=%b irsp=%b out=%0d rdy=%b rrdy=%b want 0 0 0 1 1",
               out_bus.req_valid, in_bus.rsp_valid, outstanding, in_bus.req_ready,
               out_bus.rsp_ready);
    end
    reset = 1'b0;
    for (int k = 0; k < 4; k++) begin
      drive_read(TW'($urandom));
      #1;
      tick();
      n_checks++;
      if (out_bus.req_valid !== 1'b1 || out_bus.req_tag !== IW'(k)) begin
        n_fail++;
        $display("FAIL midreset_id_%0d: got v=%b id=%0d want v=1 id=%0d", k, out_bus.req_valid,
                 out_bus.req_tag, k);
      end
    end
    in_bus.req_valid = 1'b0;
    tick();
    n_checks++;
    if (outstanding !== 3'd4 || in_bus.rsp_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL midreset_refill: got out=%0d v=%b want 4 0", outstanding, in_bus.rsp_valid);
    end
  endtask

  task automatic test_random();
    oreq_t         exp_oreq [$];
    irsp_t         exp_irsp [$];
    int            sent [$];
    bit            held [NUM_IDS];
    logic [TW-1:0] mtag [NUM_IDS];
    oreq_t         cur, got, e;
    irsp_t         r;
    logic [TW-1:0] cur_tag;
    bit            req_act, rsp_act, draining, exp_in_ready, exp_rsp_ready;
    int            rsp_idx, nheld, lowest, cyc, id;
    idle_inputs();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    for (int i = 0; i < int'(NUM_IDS); i++) held[i] = 1'b0;
    cur = '0; cur_tag = '0; req_act = 1'b0; rsp_act = 1'b0; rsp_idx = 0; cyc = 0;
    while (1) begin
      draining = (cyc >= 400);
      if (draining && !req_act && exp_oreq.size() == 0 && exp_irsp.size() == 0 &&
          sent.size() == 0) break;
      if (cyc >= 1000) begin
        n_checks++; n_fail++;
        $display("FAIL random_drain: got %0d ids pending after %0d cycles want 0", sent.size(),
                 cyc);
        break;
      end
      if (!req_act && !draining && $urandom_range(0, 9) < 7) begin
        req_act = 1'b1;
        cur.rw = ($urandom_range(0, 9) < 3);
        cur.addr = AW'($urandom); cur.data = rand_data(); cur.byteen = {$urandom, $urandom};
        cur.tag = '0;
        cur_tag = TW'($urandom);
      end
      in_bus.req_valid = req_act; in_bus.req_rw = cur.rw; in_bus.req_addr = cur.addr;
      in_bus.req_data = cur.data; in_bus.req_byteen = cur.byteen; in_bus.req_tag = cur_tag;
      out_bus.req_ready = draining ? 1'b1 : ($urandom_range(0, 9) < 7);
      in_bus.rsp_ready  = draining ? 1'b1 : ($urandom_range(0, 9) < 7);
      if (!rsp_act && sent.size() > 0 && (draining || $urandom_range(0, 1) == 1)) begin
        rsp_act = 1'b1;
        rsp_idx = $urandom_range(0, sent.size() - 1);
        out_bus.rsp_data = rand_data();
        out_bus.rsp_tag = IW'(sent[rsp_idx]);
      end
      out_bus.rsp_valid = rsp_act;
      #3;
      nheld = 0; lowest = -1;
      for (int i = int'(NUM_IDS) - 1; i >= 0; i--) begin
        if (held[i]) nheld++;
        else lowest = i;
      end
      exp_in_ready  = (exp_oreq.size() == 0 || out_bus.req_ready) &&
                      (in_bus.req_rw || nheld < int'(NUM_IDS));
      exp_rsp_ready = (exp_irsp.size() == 0) || in_bus.rsp_ready;
      n_checks++;
      if (outstanding !== CW'(nheld)) begin
        n_fail++; $display("FAIL rnd_outstanding c%0d: got %0d want %0d", cyc, outstanding, nheld);
      end
      n_checks++;
      if (in_bus.req_ready !== exp_in_ready) begin
        n_fail++;
        $display("FAIL rnd_in_req_ready c%0d: got %b want %b", cyc, in_bus.req_ready, exp_in_ready);
      end
      n_checks++;
      if (out_bus.req_valid !== (exp_oreq.size() != 0)) begin
        n_fail++;
        $display("FAIL rnd_out_req_valid c%0d: got %b want %b", cyc, out_bus.req_valid,
                 exp_oreq.size() != 0);
      end
      n_checks++;
      if (in_bus.rsp_valid !== (exp_irsp.size() != 0) || out_bus.rsp_ready !== exp_rsp_ready)
      begin
        n_fail++;
        $display("FAIL rnd_rsp_flags c%0d: got v=%b rdy=%b want v=%b rdy=%b", cyc,
                 in_bus.rsp_valid, out_bus.rsp_ready, exp_irsp.size() != 0, exp_rsp_ready);
      end
      if (exp_oreq.size() != 0 && out_bus.req_ready) begin
        got = {out_bus.req_rw, out_bus.req_addr, out_bus.req_data, out_bus.req_byteen,
               out_bus.req_tag};
        n_checks++;
        if (got !== exp_oreq[0]) begin
          n_fail++;
          $display("FAIL rnd_out_req c%0d: got rw=%b addr=%0h tag=%0d want rw=%b addr=%0h tag=%0d",
                   cyc, got.rw, got.addr, got.tag, exp_oreq[0].rw, exp_oreq[0].addr,
                   exp_oreq[0].tag);
        end
        if (!exp_oreq[0].rw) sent.push_back(int'(exp_oreq[0].tag));
        void'(exp_oreq.pop_front());
      end
      if (req_act && exp_in_ready) begin
        e = cur;
        if (!cur.rw) begin
          e.tag = IW'(lowest);
          held[lowest] = 1'b1;
          mtag[lowest] = cur_tag;
        end
        exp_oreq.push_back(e);
        req_act = 1'b0;
      end
      if (exp_irsp.size() != 0 && in_bus.rsp_ready) begin
        n_checks++;
        if (in_bus.rsp_tag !== exp_irsp[0].tag || in_bus.rsp_data !== exp_irsp[0].data) begin
          n_fail++;
          $display("FAIL rnd_in_rsp c%0d: got tag=%0h want tag=%0h", cyc, in_bus.rsp_tag,
                   exp_irsp[0].tag);
        end
        void'(exp_irsp.pop_front());
      end
      if (rsp_act && exp_rsp_ready) begin
        id = sent[rsp_idx];
        held[id] = 1'b0;
        r.tag = mtag[id];
        r.data = out_bus.rsp_data;
        exp_irsp.push_back(r);
        sent.delete(rsp_idx);
        rsp_act = 1'b0;
      end
      @(posedge clk);
      #1;
      cyc++;
    end
    idle_inputs();
    tick();
    n_checks++;
    if (outstanding !== 3'd0 || in_bus.rsp_valid !== 1'b0 || out_bus.req_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL rnd_final_idle: got out=%0d irsp=%b oreq=%b want 0 0 0", outstanding,
               in_bus.rsp_valid, out_bus.req_valid);
    end
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_single_read();
    test_pool_full();
    test_write_order();
    test_backpressure();
    test_out_of_order();
    test_alloc_free_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got no end of test within 1 ms want completion");
    $fatal(1, "simulation time limit reached");
  end

endmodule
